// File: rtl/coord_move_engine.sv
// coord_move_engine: buffered multi-axis step/dir move executor with a descriptor FIFO.
// Define STEP_COUNTER_EN to build the per-axis signed position counters.
module coord_move_engine #(
  parameter int NUM_AXES    = 2,
  parameter int ACCUM_WIDTH = 32,
  parameter int DUR_WIDTH   = 32,
  parameter int DIV_WIDTH   = 24,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                            CLK,
  input  logic                            resetn,
  input  logic [DIV_WIDTH-1:0]            clock_divisor,
  input  logic                            move_valid,
  output logic                            move_ready,
  input  logic [DUR_WIDTH-1:0]            move_duration,
  input  logic [NUM_AXES-1:0]             move_dir,
  input  logic [NUM_AXES*ACCUM_WIDTH-1:0] move_increment,
  input  logic [NUM_AXES*ACCUM_WIDTH-1:0] move_incrementincrement,
  input  logic                            abort,
  output logic [NUM_AXES-1:0]             step,
  output logic [NUM_AXES-1:0]             dir,
  output logic                            busy,
  output logic                            move_done,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic [NUM_AXES*32-1:0]          position
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int AW = ACCUM_WIDTH;
  localparam logic [AW:0] T = {2'b01, {(AW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t state, state_nx;

  logic [DUR_WIDTH-1:0]     f_dur  [FIFO_DEPTH];
  logic [NUM_AXES-1:0]      f_dir  [FIFO_DEPTH];
  logic [NUM_AXES*AW-1:0]   f_inc  [FIFO_DEPTH];
  logic [NUM_AXES*AW-1:0]   f_dinc [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic [DUR_WIDTH-1:0]     h_dur, dur, tick_cnt, tick_inc;
  logic [NUM_AXES-1:0]      h_dir, step_raw;
  logic [NUM_AXES*AW-1:0]   h_inc, h_dinc;
  logic [DIV_WIDTH-1:0]     prescaler, div_eff;
  logic                     push, pop, tick, last;

  assign move_ready = ~fifo_count[PW];
  assign push       = move_valid & move_ready & ~abort;
  assign pop        = (state == LOAD);
  assign busy       = (state != IDLE);
  assign h_dur      = f_dur[rd_ptr];
  assign h_dir      = f_dir[rd_ptr];
  assign h_inc      = f_inc[rd_ptr];
  assign h_dinc     = f_dinc[rd_ptr];
  assign div_eff    = (clock_divisor == '0) ? DIV_WIDTH'(1) : clock_divisor;
  assign tick       = (state == RUN) & (prescaler == div_eff);
  assign tick_inc   = tick_cnt + 1'b1;
  assign last       = tick & (tick_inc == dur);
  assign step       = step_raw & {NUM_AXES{~abort}};
  assign move_done  = ~abort & (((state == LOAD) & (h_dur == '0)) | last);

  always_ff @(posedge CLK)
    if (push) begin
      f_dur[wr_ptr]  <= move_duration;
      f_dir[wr_ptr]  <= move_dir;
      f_inc[wr_ptr]  <= move_increment;
      f_dinc[wr_ptr] <= move_incrementincrement;
    end

  always_ff @(posedge CLK or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    if (abort) state_nx = IDLE;
    else if (state == IDLE) state_nx = (fifo_count != '0) ? LOAD : IDLE;
    else if (state == LOAD) state_nx = (h_dur != '0) ? RUN : (|fifo_count[PW:1] ? LOAD : IDLE);
    else if (last) state_nx = (fifo_count != '0) ? LOAD : IDLE;
  end

  always_ff @(posedge CLK or negedge resetn)
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      prescaler  <= '0;
      tick_cnt   <= '0;
      dur        <= '0;
      dir        <= '0;
    end else if (abort) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      wr_ptr     <= wr_ptr + PW'(push);
      rd_ptr     <= rd_ptr + PW'(pop);
      fifo_count <= fifo_count + (PW+1)'(push) - (PW+1)'(pop);
      if (state == LOAD) begin
        dur       <= h_dur;
        dir       <= h_dir;
        prescaler <= '0;
        tick_cnt  <= '0;
      end else if (state == RUN) begin
        prescaler <= tick ? '0 : prescaler + 1'b1;
        if (tick) tick_cnt <= tick_inc;
      end
    end

  for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
    logic [AW-1:0] acc, vel, dlt, vsat;
    logic [AW:0]   sum, sub;
    logic [AW+1:0] vnx;
    assign sum = {1'b0, acc} + {1'b0, vel};
    assign sub = sum - T;
    assign step_raw[i] = tick & (sum[AW] | sum[AW-1]);
    // two's-complement sum two bits wider than the velocity, clamped only in the direction of the delta
    assign vnx  = {2'b00, vel} + {{2{dlt[AW-1]}}, dlt};
    assign vsat = vnx[AW+1] ? '0 :
                  (~dlt[AW-1] & (|dlt) & (|vnx[AW:AW-1])) ? {1'b0, {(AW-1){1'b1}}} : vnx[AW-1:0];
    always_ff @(posedge CLK or negedge resetn)
      if (!resetn) begin
        acc <= '0;
        vel <= '0;
        dlt <= '0;
      end else if (state == LOAD) begin
        acc <= '0;
        vel <= h_inc[i*AW +: AW];
        dlt <= h_dinc[i*AW +: AW];
      end else if (tick) begin
        acc <= step_raw[i] ? sub[AW-1:0] : sum[AW-1:0];
        vel <= vsat;
      end
`ifdef STEP_COUNTER_EN
    logic [31:0] pos;
    always_ff @(posedge CLK or negedge resetn)
      if (!resetn) pos <= '0;
      else if (step[i]) pos <= dir[i] ? pos + 1'b1 : pos - 1'b1;
    assign position[i*32 +: 32] = pos;
`else
    assign position[i*32 +: 32] = '0;
`endif
  end
endmodule

// File: tb/tb_coord_move_engine.sv
// tb_coord_move_engine: directed moves with a queue of expected step/done events checked by a monitor.
module tb_coord_move_engine;
  localparam int NA = 2, AW = 8, DW = 16, VW = 8, FD = 4;
  logic CLK = 0, resetn = 0;
  logic [VW-1:0] clock_divisor = 1;
  logic move_valid = 0, abort = 0, move_ready, busy, move_done;
  logic [DW-1:0] move_duration = '0;
  logic [NA-1:0] move_dir = '0, step, dir;
  logic [NA*AW-1:0] move_increment = '0, move_incrementincrement = '0;
  logic [2:0] fifo_count;
  logic [NA*32-1:0] position;
  int tests = 0, fails = 0, cyc = 0, ref_cyc = 0;
  logic busy_q = 0;
  typedef struct packed {logic [15:0] gap; logic [1:0] st; logic dn; logic [1:0] dr;} ev_t;
  ev_t exp_q[$];
  logic [31:0] exp_pos [NA];

  coord_move_engine #(.NUM_AXES(NA), .ACCUM_WIDTH(AW), .DUR_WIDTH(DW), .DIV_WIDTH(VW), .FIFO_DEPTH(FD)) dut (
    .CLK(CLK), .resetn(resetn), .clock_divisor(clock_divisor),
    .move_valid(move_valid), .move_ready(move_ready), .move_duration(move_duration),
    .move_dir(move_dir), .move_increment(move_increment),
    .move_incrementincrement(move_incrementincrement), .abort(abort),
    .step(step), .dir(dir), .busy(busy), .move_done(move_done),
    .fifo_count(fifo_count), .position(position));

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // gap is counted from the previous event, or from the LOAD cycle when busy rises out of idle
  task automatic expect_ev(input int gap, input logic [1:0] st, input logic dn, input logic [1:0] dr);
    exp_q.push_back('{gap: 16'(gap), st: st, dn: dn, dr: dr});
    for (int i = 0; i < NA; i++)
      if (st[i]) exp_pos[i] = dr[i] ? exp_pos[i] + 1 : exp_pos[i] - 1;
  endtask

  task automatic send(input int du, input logic [1:0] dr, input int i0, input int i1, input int d0, input int d1);
    @(negedge CLK); #1;
    move_duration = DW'(du);
    move_dir = dr;
    move_increment = {AW'(i1), AW'(i0)};
    move_incrementincrement = {AW'(d1), AW'(d0)};
    move_valid = 1;
    @(negedge CLK); #1;
    move_valid = 0;
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 50) begin @(negedge CLK); #1; n++; end
    chk("busy_rise", busy, 1);
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while ((busy || fifo_count != 0 || exp_q.size() != 0) && n < lim) begin @(negedge CLK); #1; n++; end
    chk("idle_reached", 64'(n < lim), 1);
  endtask

  always @(negedge CLK) begin
    ev_t e;
    cyc++;
    if (busy && !busy_q) ref_cyc = cyc;
    if (step != 0 || move_done) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event: step=%b done=%b dir=%b at cycle %0d", step, move_done, dir, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("event{gap,step,done,dir}", {16'(cyc - ref_cyc), step, move_done, dir}, e);
      end
      ref_cyc = cyc;
    end
    busy_q = busy;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    exp_pos = '{default: '0};
    @(negedge CLK); #1;
    chk("rst_step", step, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", move_done, 0);
    chk("rst_ready", move_ready, 1);
    chk("rst_count", fifo_count, 0);
    chk("rst_dir", dir, 0);
    chk("rst_position", position, 0);
    @(negedge CLK); #1 resetn = 1;
    repeat (2) @(negedge CLK);
    #1 chk("post_rst_busy", busy, 0);

    // constant velocity 64: a step every second tick
    clock_divisor = 1;
    expect_ev(4, 2'b01, 0, 2'b01); expect_ev(4, 2'b01, 0, 2'b01);
    expect_ev(4, 2'b01, 0, 2'b01); expect_ev(4, 2'b01, 1, 2'b01);
    send(8, 2'b01, 64, 0, 0, 0);
    n = 0;
    while (!move_done && n < 100) begin @(negedge CLK); #1; n++; end
    chk("t1_done_seen", 64'(n < 100), 1);
    chk("t1_busy_at_done", busy, 1);
    @(negedge CLK); #1;
    chk("t1_busy_after_done", busy, 0);
    wait_idle(50);

    // accelerating: velocities 0,16,...,112 step on ticks 5,7,8
    expect_ev(10, 2'b01, 0, 2'b01); expect_ev(4, 2'b01, 0, 2'b01); expect_ev(2, 2'b01, 1, 2'b01);
    send(8, 2'b01, 0, 0, 16, 0);
    wait_idle(100);
    // delta 100 saturates at 127: steps on ticks 3,4,5
    expect_ev(6, 2'b01, 0, 2'b01); expect_ev(2, 2'b01, 0, 2'b01); expect_ev(2, 2'b01, 1, 2'b01);
    send(5, 2'b01, 0, 0, 100, 0);
    wait_idle(100);

    // long stall move, then four queued moves run back-to-back
    expect_ev(40, 2'b00, 1, 2'b01);
    expect_ev(5, 2'b01, 1, 2'b01);
    expect_ev(1, 2'b00, 1, 2'b01);
    expect_ev(3, 2'b01, 1, 2'b00);
    expect_ev(5, 2'b01, 0, 2'b01); expect_ev(2, 2'b00, 1, 2'b01);
    send(20, 2'b01, 0, 0, 0, 0);
    wait_busy();
    send(2, 2'b01, 64, 0, 0, 0);
    send(0, 2'b01, 0, 0, 0, 0);
    send(1, 2'b00, 128, 0, 0, 0);
    chk("t3_ready_before_full", move_ready, 1);
    send(3, 2'b01, 64, 0, 0, 0);
    chk("t3_count_full", fifo_count, 4);
    chk("t3_ready_full", move_ready, 0);
    move_duration = 16'd9; move_valid = 1;
    @(negedge CLK); #1;
    move_valid = 0;
    chk("t3_count_no_push_when_full", fifo_count, 4);
    wait_idle(300);

    // two axes, divisor 3, run twice back-to-back
    clock_divisor = 3;
    expect_ev(4, 2'b01, 0, 2'b01); expect_ev(4, 2'b01, 0, 2'b01);
    expect_ev(4, 2'b01, 0, 2'b01); expect_ev(4, 2'b11, 1, 2'b01);
    expect_ev(5, 2'b01, 0, 2'b01); expect_ev(4, 2'b01, 0, 2'b01);
    expect_ev(4, 2'b01, 0, 2'b01); expect_ev(4, 2'b11, 1, 2'b01);
    send(4, 2'b01, 128, 32, 0, 0);
    send(4, 2'b01, 128, 32, 0, 0);
    chk("t4_dir", dir, 2'b01);
    wait_idle(200);

    // abort mid-run with two entries queued; a push alongside abort is dropped
    clock_divisor = 1;
    send(50, 2'b10, 0, 0, 0, 0);
    wait_busy();
    send(50, 2'b10, 0, 0, 0, 0);
    send(50, 2'b10, 0, 0, 0, 0);
    chk("t5_count_queued", fifo_count, 2);
    move_duration = '0; move_valid = 1; abort = 1;
    @(negedge CLK); #1;
    abort = 0; move_valid = 0;
    chk("t5_count", fifo_count, 0);
    chk("t5_busy", busy, 0);
    chk("t5_step", step, 0);
    chk("t5_done", move_done, 0);
    chk("t5_ready", move_ready, 1);
    chk("t5_dir_held", dir, 2'b10);
    repeat (3) @(negedge CLK);
    #1 chk("t5_stays_idle", busy, 0);
    // zero-duration move: done in its LOAD cycle, dir still the held value there
    expect_ev(0, 2'b00, 1, 2'b10);
    send(0, 2'b01, 64, 64, 0, 0);
    wait_idle(50);
    chk("t5_dir_loaded", dir, 2'b01);

    repeat (3) @(negedge CLK);
    #1 chk("queue_drained", exp_q.size(), 0);
`ifdef STEP_COUNTER_EN
    chk("position0", position[31:0], exp_pos[0]);
    chk("position1", position[63:32], exp_pos[1]);
`else
    chk("position0", position[31:0], 0);
    chk("position1", position[63:32], 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/coord_move_engine.md
Name: coord_move_engine

Overview:
- Buffered, multi-axis coordinated-move executor. Successor to the single-axis, unbuffered, latch-triggered move timer.
- Accepts complete move descriptors over a valid/ready interface into a FIFO.
- Executes moves back-to-back on a common prescaled tick. Each axis emits step/dir through its own velocity accumulator.
- Sits between the SPI message decoder and the per-axis H-bridge drivers.

Parameters:
NUM_AXES, 2, number of independent step/dir channels
ACCUM_WIDTH, 32, per-axis accumulator/velocity width in bits; step threshold T = 2^(ACCUM_WIDTH-1)
DUR_WIDTH, 32, move duration width (ticks)
DIV_WIDTH, 24, clock divisor width
FIFO_DEPTH, 4, move buffer entries; must be a power of two and at least 2

Ports:
CLK  in  1  system clock
resetn  in  1  asynchronous active-low reset
clock_divisor  in  DIV_WIDTH  tick period is clock_divisor+1 CLK cycles; a value of 0 behaves as 1
move_valid  in  1  descriptor present
move_ready  out  1  FIFO can accept a descriptor
move_duration  in  DUR_WIDTH  move length in ticks
move_dir  in  NUM_AXES  per-axis direction
move_increment  in  NUM_AXES*ACCUM_WIDTH  per-axis initial velocity, unsigned, axis 0 in LSBs
move_incrementincrement  in  NUM_AXES*ACCUM_WIDTH  per-axis per-tick velocity delta, signed
abort  in  1  flush FIFO and stop immediately
step  out  NUM_AXES  one-cycle step pulses
dir  out  NUM_AXES  registered direction
busy  out  1  high in LOAD or RUN
move_done  out  1  one-cycle pulse when a move completes
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied FIFO entries
position  out  NUM_AXES*32  signed step position; only active with STEP_COUNTER_EN

Behaviour:
Reset values:
- step, dir, busy, move_done = 0; fifo_count = 0; move_ready = 1; position = 0; FSM in IDLE.
- FIFO pointers, accumulators, velocities, prescaler and tick counter all cleared.

FIFO:
- A push occurs when move_valid & move_ready on a CLK edge.
- move_ready = (fifo_count < FIFO_DEPTH).
- Push and pop in the same cycle leave fifo_count unchanged. A push while full is impossible because ready is low.
- Pointers wrap modulo FIFO_DEPTH.

FSM:
- IDLE: when fifo_count != 0, go to LOAD on the next edge.
- LOAD (exactly 1 cycle):
  - Pop the head entry and latch duration, velocity v[i] = increment, acc_delta[i] = incrementincrement, and dir <= move_dir.
  - Clear accum[i], prescaler and tick_cnt.
  - If duration == 0: pulse move_done and go to IDLE (or LOAD if more entries are queued). Otherwise go to RUN.
- RUN:
  - The prescaler increments every cycle. A tick fires when prescaler == max(clock_divisor,1), and the prescaler then returns to 0.
  - On each tick, for every axis: sum = accum + v (ACCUM_WIDTH+1 bits).
    - If sum >= T: step[i] = 1 for that single cycle and accum <= sum - T.
    - Otherwise accum <= sum.
  - After the accumulate, v <= v + acc_delta, saturating to the range [0, T-1]. Velocity never wraps and never goes negative.
  - tick_cnt increments on each tick. On the tick where tick_cnt reaches duration:
    - Pulse move_done in the same cycle as that tick's steps.
    - Go to LOAD if fifo_count != 0 (back-to-back moves, zero idle cycles), else go to IDLE.

Timing guarantees:
- The minimum tick period of 2 cycles guarantees step returns low between pulses.
- dir changes only in LOAD, which is at least 2 cycles before any step of the new move.
- First tick of a move occurs max(clock_divisor,1)+1 cycles after LOAD.

Other rules:
- clock_divisor is sampled live. A change mid-move applies from the next prescaler comparison.
- abort (synchronous, highest priority):
  - On the edge it is sampled: FIFO emptied, FSM forced to IDLE, step = 0, move_done not pulsed.
  - dir holds its value.
  - A push in the same cycle as abort is discarded.
- Asserting resetn mid-move stops all outputs immediately (asynchronous).

Optional Feature:
- Macro: STEP_COUNTER_EN.
- Defined: position[i] increments by 1 on each step[i] when dir[i]=1 and decrements by 1 when dir[i]=0, wrapping at 32 bits. It is cleared only by reset; abort does not clear it.
- Undefined: no counters are built and position is tied to 0. The port list is identical in both builds.

Test Plan:
1. ACCUM_WIDTH=8 (T=128), divisor 1, one axis: v=64, delta=0, duration 8 -> exactly 4 step pulses, on ticks 2,4,6,8; move_done coincides with tick 8; busy falls the cycle after.
2. Same setup with v=0, delta=+16, duration 8 -> velocities 0,16,...,112 feed the accumulator; total sum 448 gives exactly 3 steps; velocity saturation checked with delta=+100 (clamps at 127).
3. Push 5 moves with FIFO_DEPTH=4 while the engine is stalled by a long first move -> move_ready low after the 4th queued entry; all 5 moves execute back-to-back; exactly one LOAD cycle between consecutive move_done and the next move's first prescaler cycle.
4. Two axes, dirs 1/0, v=128 and 32, duration 4, divisor 3 -> axis0 steps every tick (4 pulses, 4 cycles apart); axis1 steps once on tick 4; dir set in LOAD and stable throughout.
5. abort asserted mid-RUN with 2 entries queued -> next cycle: fifo_count=0, busy=0, step=0, no move_done. A duration-0 descriptor -> move_done pulse and no steps.
6. With STEP_COUNTER_EN: run test 4 twice -> position = {+8, -2}. Without the macro -> position stays 0.
